// File: rtl/bit_packer.sv
// bit_packer: packs right-aligned variable-length codes into big-endian
// output words of OUT_W bits. Optional 0xFF/0x00 byte stuffing, flush with
// 1-padding to a byte boundary and a final partial word tagged out_last.
// Valid/ready on both sides; in_ready depends on registered state only.
module bit_packer #(
  parameter int IN_W     = 24,
  parameter int OUT_W    = 32,
  parameter int STUFF_EN = 1,
  parameter int CNT_W    = $clog2(IN_W + 1)
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [CNT_W-1:0]                in_len,
  input  logic [IN_W-1:0]                 in_bin,
  input  logic                            in_valid,
  input  logic                            in_flush,
  output logic                            in_ready,
  output logic [OUT_W-1:0]                out_bin,
  output logic [$clog2(OUT_W/8+1)-1:0]    out_bytes,
  output logic                            out_valid,
  output logic                            out_last,
  input  logic                            out_ready
);

  localparam int NB     = OUT_W / 8;
  localparam int SLOT_W = $clog2(NB + 1);
  // Logical accumulator capacity used for the in_ready decision.
  localparam int ACC_W  = IN_W + OUT_W + 8;
  // Physical storage carries one extra byte so flush padding of a beat
  // accepted at full logical capacity still fits.
  localparam int ACC_P  = ACC_W + 8;
  localparam int LEN_W  = $clog2(ACC_P + 1);
  localparam int APP_W  = IN_W + 7;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_LAST  = 2'd2
  } state_t;

  // Registered state
  state_t                  state_q,     state_d;
  logic                    en_q;
  logic [ACC_P-1:0]        acc_q,       acc_d;
  logic [LEN_W-1:0]        acc_len_q,   acc_len_d;
  logic [OUT_W-1:0]        word_q,      word_d;
  logic [SLOT_W-1:0]       slots_q,     slots_d;
  logic                    pend_q,      pend_d;
  logic [OUT_W-1:0]        out_bin_q,   out_bin_d;
  logic [SLOT_W-1:0]       out_bytes_q, out_bytes_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q,  out_last_d;

  // Combinational working values
  logic                    stall;
  logic                    accept;
  logic                    full;
  logic                    final_go;
  logic                    done;
  logic [OUT_W-1:0]        word_v;
  logic [7:0]              byte_v;
  logic                    pend_v;
  logic [IN_W-1:0]         code_v;
  logic [APP_W-1:0]        app_v;
  logic [ACC_P-1:0]        shifted_v;
  int                      slots_i;
  int                      take_i;
  int                      avail_i;
  int                      len_c;
  int                      len_mid;
  int                      pad_i;
  int                      app_len;

  assign in_ready  = en_q & (state_q == S_RUN) &
                     ((int'(acc_len_q) + IN_W) <= ACC_W);
  assign out_bin   = out_bin_q;
  assign out_bytes = out_bytes_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  // Byte assembler: moves whole bytes from the accumulator head into free
  // word slots (with stuffing), then decides whether a word leaves this cycle.
  always_comb begin
    stall    = out_valid_q & ~out_ready;
    word_v   = word_q;
    pend_v   = pend_q;
    byte_v   = 8'h00;
    slots_i  = int'(slots_q);
    take_i   = 0;
    avail_i  = int'(acc_len_q) / 8;
    if (!stall) begin
      for (int i = 0; i < NB; i++) begin
        if (slots_i < NB) begin
          if (pend_v) begin
            // Stuffed zero left over from an FF in the previous word's last slot.
            word_v[OUT_W-1-8*slots_i -: 8] = 8'h00;
            slots_i = slots_i + 1;
            pend_v  = 1'b0;
          end else if (take_i < avail_i) begin
            byte_v  = acc_q[ACC_P-1-8*take_i -: 8];
            word_v[OUT_W-1-8*slots_i -: 8] = byte_v;
            slots_i = slots_i + 1;
            take_i  = take_i + 1;
            if ((STUFF_EN != 0) && (byte_v == 8'hFF)) begin
              if (slots_i < NB) begin
                word_v[OUT_W-1-8*slots_i -: 8] = 8'h00;
                slots_i = slots_i + 1;
              end else begin
                pend_v = 1'b1;
              end
            end
          end
        end
      end
    end
    full     = (slots_i == NB);
    // Final partial word goes out once everything buffered has been placed.
    final_go = (state_q == S_FLUSH) && (acc_len_q == '0) && !pend_q && !stall;
    done     = (state_q == S_LAST) && out_valid_q && out_ready && out_last_q;
  end

  // Accumulator append: drop consumed bytes, then place the accepted code
  // (plus flush padding) directly behind the remaining bits.
  always_comb begin
    accept    = in_valid & in_ready;
    len_c     = (int'(in_len) > IN_W) ? IN_W : int'(in_len);
    code_v    = in_bin & ((IN_W'(1) << len_c) - IN_W'(1));
    shifted_v = acc_q << (8 * take_i);
    len_mid   = int'(acc_len_q) - 8 * take_i;
    pad_i     = 0;
    if (accept && in_flush) begin
      pad_i = (8 - ((len_mid + len_c) % 8)) % 8;
    end
    app_len   = accept ? (len_c + pad_i) : 0;
    app_v     = (APP_W'(code_v) << pad_i) | ((APP_W'(1) << pad_i) - APP_W'(1));
    if (app_len != 0) begin
      acc_d = shifted_v | (ACC_P'(app_v) << (ACC_P - len_mid - app_len));
    end else begin
      acc_d = shifted_v;
    end
    acc_len_d = LEN_W'(len_mid + app_len);
    if (done) begin
      acc_d     = '0;
      acc_len_d = '0;
    end
  end

  // Word hand-off, output register next state and control state next state.
  always_comb begin
    word_d      = word_v;
    slots_d     = SLOT_W'(slots_i);
    pend_d      = pend_v;
    out_bin_d   = out_bin_q;
    out_bytes_d = out_bytes_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    state_d     = state_q;
    if (!stall) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (full) begin
      out_bin_d   = word_v;
      out_bytes_d = SLOT_W'(NB);
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      word_d      = '0;
      slots_d     = '0;
    end else if (final_go) begin
      out_bin_d   = word_q;
      out_bytes_d = slots_q;
      out_valid_d = 1'b1;
      out_last_d  = 1'b1;
      word_d      = '0;
      slots_d     = '0;
    end
    unique case (state_q)
      S_RUN:   if (accept && in_flush) state_d = S_FLUSH;
      S_FLUSH: if (final_go)           state_d = S_LAST;
      S_LAST:  if (done)               state_d = S_RUN;
      default:                         state_d = S_RUN;
    endcase
    if (done) begin
      word_d  = '0;
      slots_d = '0;
      pend_d  = 1'b0;
    end
  end

  // All registers: async active-low reset discards any buffered bits.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_RUN;
      en_q        <= 1'b0;
      acc_q       <= '0;
      acc_len_q   <= '0;
      word_q      <= '0;
      slots_q     <= '0;
      pend_q      <= 1'b0;
      out_bin_q   <= '0;
      out_bytes_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= 1'b1;
      acc_q       <= acc_d;
      acc_len_q   <= acc_len_d;
      word_q      <= word_d;
      slots_q     <= slots_d;
      pend_q      <= pend_d;
      out_bin_q   <= out_bin_d;
      out_bytes_q <= out_bytes_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// Testbench for bit_packer: directed scenarios plus randomized images,
// checked against a bit-queue reference model of the packing rules.
module tb_bit_packer;

  localparam int IN_W  = 24;
  localparam int OUT_W = 32;
  localparam int NB    = OUT_W / 8;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int OB_W  = $clog2(NB + 1);

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [CNT_W-1:0]  in_len = '0;
  logic [IN_W-1:0]   in_bin = '0;
  logic              in_valid = 1'b0;
  logic              in_flush = 1'b0;
  logic              in_ready;
  logic [OUT_W-1:0]  out_bin;
  logic [OB_W-1:0]   out_bytes;
  logic              out_valid;
  logic              out_last;
  logic              out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic              m_bits[$];
  logic [7:0]        m_bytes[$];
  logic [OUT_W-1:0]  ex_data[$];
  int                ex_bytes[$];
  logic              ex_last[$];
  int                img_bits = 0;

  // Last observed output word
  logic [OUT_W-1:0]  obs_data = '0;
  int                obs_bytes = 0;
  logic              obs_last = 1'b0;
  int                obs_cnt = 0;

  logic              stall_prev = 1'b0;
  logic [63:0]       held = '0;
  logic              rnd_ready = 1'b0;
  logic              ready_force = 1'b1;

  bit_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .STUFF_EN(1)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_len    (in_len),
    .in_bin    (in_bin),
    .in_valid  (in_valid),
    .in_flush  (in_flush),
    .in_ready  (in_ready),
    .out_bin   (out_bin),
    .out_bytes (out_bytes),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [OUT_W-1:0] w, input int n, input logic l);
    ex_data.push_back(w);
    ex_bytes.push_back(n);
    ex_last.push_back(l);
  endtask

  // Bits in order, then bytes (with FF->FF 00), then words of NB bytes.
  task automatic model_beat(input int len, input logic [IN_W-1:0] bin, input logic fl);
    int l;
    int n;
    logic [7:0] b;
    logic [OUT_W-1:0] w;
    l = (len > IN_W) ? IN_W : len;
    for (int i = l - 1; i >= 0; i--) begin
      m_bits.push_back(bin[i]);
      img_bits++;
    end
    if (fl) begin
      while ((img_bits % 8) != 0) begin
        m_bits.push_back(1'b1);
        img_bits++;
      end
    end
    while (m_bits.size() >= 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], m_bits.pop_front()};
      m_bytes.push_back(b);
      if (b == 8'hFF) m_bytes.push_back(8'h00);
    end
    while (m_bytes.size() >= NB) begin
      w = '0;
      for (int i = 0; i < NB; i++) w = {w[OUT_W-9:0], m_bytes.pop_front()};
      push_exp(w, NB, 1'b0);
    end
    if (fl) begin
      n = m_bytes.size();
      w = '0;
      for (int i = 0; i < NB; i++) w = {w[OUT_W-9:0], (i < n) ? m_bytes.pop_front() : 8'h00};
      push_exp(w, n, 1'b1);
      img_bits = 0;
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_bytes.delete();
    ex_data.delete();
    ex_bytes.delete();
    ex_last.delete();
    img_bits = 0;
  endtask

  // out_ready driver: fixed level or random.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Monitor: feeds accepted beats to the model, checks handshaken words.
  always @(negedge clk) begin
    if (!nrst) begin
      stall_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) model_beat(int'(in_len), in_bin, in_flush);
      if (stall_prev && out_valid)
        check_eq("stable", 64'({out_bytes, out_last, out_bin}), held);
      if (out_valid && out_ready) begin
        if (ex_data.size() == 0) begin
          check_eq("extra_word", 64'(ex_data.size()), 64'(1));
        end else begin
          check_eq("word_data", 64'(out_bin), 64'(ex_data.pop_front()));
          check_eq("word_bytes", 64'(out_bytes), 64'(ex_bytes.pop_front()));
          check_eq("word_last", 64'(out_last), 64'(ex_last.pop_front()));
        end
        obs_data  = out_bin;
        obs_bytes = int'(out_bytes);
        obs_last  = out_last;
        obs_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      held = 64'({out_bytes, out_last, out_bin});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int len, input logic [IN_W-1:0] bin, input logic fl);
    int n;
    n = 0;
    in_len   = CNT_W'(len);
    in_bin   = bin;
    in_flush = fl;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 500);
    check_eq("send_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((ex_data.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(ex_data.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt0;
    int nb;
    logic fell;
    logic [IN_W-1:0] bin_r;

    // Reset state
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(out_valid), 64'(0));
    check_eq("rst_last", 64'(out_last), 64'(0));
    check_eq("rst_bin", 64'(out_bin), 64'(0));
    check_eq("rst_bytes", 64'(out_bytes), 64'(0));
    check_eq("rst_in_ready", 64'(in_ready), 64'(0));
    nrst = 1'b1;
    cycles(1);
    check_eq("ready_up", 64'(in_ready), 64'(1));

    // Four bytes -> one word, two cycles after the last beat
    send(8, 24'h12, 1'b0);
    send(8, 24'h34, 1'b0);
    send(8, 24'h56, 1'b0);
    send(8, 24'h78, 1'b0);
    check_eq("lat_pre", 64'(out_valid), 64'(0));
    cycles(1);
    check_eq("lat_valid", 64'(out_valid), 64'(1));
    check_eq("lat_data", 64'(out_bin), 64'(32'h12345678));
    wait_drain(50);

    // Stuffing inside a word
    send(16, 24'h00FFAB, 1'b0);
    send(8, 24'h0000CD, 1'b0);
    wait_drain(50);
    check_eq("t2_word", 64'(obs_data), 64'(32'hFF00ABCD));

    // Stuffed zero spills into the final word
    send(24, 24'hAABBCC, 1'b0);
    send(8, 24'h0000FF, 1'b1);
    wait_drain(50);
    check_eq("t3_data", 64'(obs_data), 64'(0));
    check_eq("t3_bytes", 64'(obs_bytes), 64'(1));
    check_eq("t3_last", 64'(obs_last), 64'(1));

    // Flush padding, then flush on an empty packer
    send(4, 24'h00000A, 1'b1);
    wait_drain(50);
    check_eq("t4_data", 64'(obs_data), 64'(32'hAF000000));
    check_eq("t4_bytes", 64'(obs_bytes), 64'(1));
    cnt0 = obs_cnt;
    send(0, 24'h0, 1'b1);
    wait_drain(50);
    check_eq("t4b_cnt", 64'(obs_cnt), 64'(cnt0 + 1));
    check_eq("t4b_bytes", 64'(obs_bytes), 64'(0));
    check_eq("t4b_last", 64'(obs_last), 64'(1));

    // Backpressure: stream until in_ready drops
    ready_force = 1'b0;
    cycles(2);
    fell = 1'b0;
    in_len = CNT_W'(24);
    in_bin = 24'h123456;
    in_flush = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!in_ready) begin
        fell = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("bp_fell", 64'(fell), 64'(1));
    check_eq("bp_valid", 64'(out_valid), 64'(1));
    cycles(5);
    ready_force = 1'b1;
    send(0, 24'h0, 1'b1);
    wait_drain(200);
    check_eq("bp_last", 64'(obs_last), 64'(1));

    // Reset mid-word discards buffered bytes
    send(8, 24'hA1, 1'b0);
    send(8, 24'hA2, 1'b0);
    send(8, 24'hA3, 1'b0);
    cycles(3);
    nrst = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_valid", 64'(out_valid), 64'(0));
    check_eq("mid_rst_bin", 64'(out_bin), 64'(0));
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'(0));
    cycles(2);
    nrst = 1'b1;
    cycles(1);
    check_eq("mid_ready_up", 64'(in_ready), 64'(1));
    send(8, 24'h11, 1'b0);
    send(0, 24'h0, 1'b1);
    wait_drain(50);
    check_eq("mid_data", 64'(obs_data), 64'(32'h11000000));
    check_eq("mid_bytes", 64'(obs_bytes), 64'(1));

    // Randomized images with random backpressure
    rnd_ready = 1'b1;
    for (int img = 0; img < 25; img++) begin
      nb = $urandom_range(1, 30);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) cycles(1);
        bin_r = ($urandom_range(0, 3) == 0) ? '1 : IN_W'($urandom);
        send($urandom_range(0, 31), bin_r, (b == nb - 1) ? 1'b1 : 1'b0);
      end
      wait_drain(2000);
    end
    rnd_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_packer.md
Name: bit_packer

Overview:
- Parametrised successor to the entropy-coder byte concatenator.
- Packs variable-length, right-aligned binary codes into fixed-width, big-endian output words.
- Optional JPEG byte stuffing inserts 0x00 after every 0xFF.
- Flush pads with 1s to a byte boundary, then drains the final partial word with a byte count and a last flag.
- Full valid/ready backpressure on both sides. Sits between the Huffman encoder and the bitstream writer.

Parameters:
- IN_W, 24: maximum input code length in bits (1..32).
- OUT_W, 32: output word width in bits; multiple of 8, range 8..64.
- STUFF_EN, 1: 1 = insert 0x00 after each emitted 0xFF byte; 0 = no stuffing.
- CNT_W, $clog2(IN_W+1): width of in_len.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- in_len  in  CNT_W  number of valid LSBs of in_bin (0..IN_W).
- in_bin  in  IN_W  code, right-aligned; bits at or above in_len are ignored.
- in_valid  in  1  input valid.
- in_flush  in  1  qualifies the current beat as the final symbol of the image.
- in_ready  out  1  input accepted when in_valid & in_ready.
- out_bin  out  OUT_W  packed word; first byte in [OUT_W-1:OUT_W-8]; unused slots are 0.
- out_bytes  out  $clog2(OUT_W/8+1)  number of valid bytes in out_bin.
- out_valid  out  1  output valid; held with stable data until accepted.
- out_last  out  1  marks the final word of the image.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async): out_valid=0, out_last=0, out_bin=0, out_bytes=0, in_ready=0 while nrst is low. Accumulator, slot count and pending-zero flag clear; state=RUN. in_ready rises the first cycle after release.
- Accumulator: ACC_W = IN_W+OUT_W+8 bits, left-aligned, with acc_len.
- Append: an accepted beat appends in_len bits. in_len > IN_W is treated as IN_W. in_len=0 is a no-op except for flush.
- in_ready = (state==RUN) & (acc_len + IN_W <= ACC_W). It is combinational from registered state only; it has no combinational path from in_valid or out_ready.
- Byte extraction, each cycle the assembler is not stalled:
  - Move whole bytes from the accumulator head into free word slots, up to OUT_W/8 slots per cycle.
  - With STUFF_EN, each 0xFF consumes two slots (FF, 00).
  - If 0xFF lands in the last slot, set pending_zero; that 0x00 fills slot 0 of the next word before any new byte.
  - Bytes placed in a cycle include bits appended in the previous cycle, not the same cycle.
- Word hand-off:
  - When all slots are full, transfer to the output register: out_valid=1, out_bytes=OUT_W/8.
  - The assembler stalls while out_valid & ~out_ready.
  - The transfer happens in the same cycle the previous word is accepted, so there is no bubble.
- Latency: the last bit that completes a word appears on out_bin 2 cycles after its input beat. At steady state, one word per cycle.
- States:
  - RUN: on an accepted beat with in_flush=1, append the code, then append (8 - acc_len mod 8) mod 8 ones. Go to FLUSH.
  - FLUSH: in_ready=0. Drain full words normally. When the accumulator is empty and pending_zero=0, emit the remaining slots as the final word with out_last=1 and out_bytes equal to the used slots. If 0 slots are used, emit a zero word with out_bytes=0, out_last=1. Go to LAST.
  - LAST: wait for out_ready on the final word, then return to RUN with everything cleared.
- Padding ones are real data: a padded 0xFF is stuffed.
- Reset asserted mid-image discards all buffered bits. No partial word is emitted.

Test Plan:
- STUFF_EN=0, four 8-bit beats 0x12, 0x34, 0x56, 0x78, out_ready=1 -> one word 0x12345678, out_bytes=4, out_last=0, 2 cycles after the 4th beat.
- STUFF_EN=1, 16-bit 0xFFAB then 8-bit 0xCD -> 0xFF00ABCD, out_bytes=4, out_last=0; only bytes AB, CD are consumed from the input after the FF.
- Split stuff: 24-bit 0xAABBCC, then 8-bit 0xFF with in_flush -> 0xAABBCCFF (bytes=4, last=0), then 0x00000000 (bytes=1, last=1).
- Flush padding: 4-bit 1010 with in_flush -> 0xAF000000, bytes=1, last=1. Then flush with in_len=0 on an empty packer -> 0x00000000, bytes=0, last=1.
- Backpressure: out_ready=0 while streaming 24-bit beats 0x123456 -> in_ready falls once acc_len > ACC_W-IN_W. Release out_ready -> all bytes emerge in order, none lost or duplicated; out_bin stays stable while stalled.
- Drive nrst low mid-word after 3 bytes, then release -> outputs are 0 immediately and no stale word appears. The next beat 8-bit 0x11 starts a fresh word (0x11 in byte 0).
